sram_access_ctrl: RTL
=====================

Name: sram_access_ctrl

Overview:
Front-end controller for one dual-port set-associative SRAM instance (one read port, one write port, per-way write mask, 1-cycle read latency, internal same-set write-to-read bypass) inside the L1 cache. On reset it sweeps every set to zero. It then serves one read requester and two write requesters, refill and update, with round-robin arbitration between the writers. It also runs an on-demand flush sweep that zeroes the whole array.

Parameters:
GEN_WIDTH, 32, bits per way entry
NUM_SET, 32, number of sets (need not be a power of 2, must be >= 2)
NUM_WAY, 2, ways per set (>= 1)
SET_DEPTH, 5, set index width (2^SET_DEPTH >= NUM_SET)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rd_req_valid_i / rd_req_ready_o  in/out  1/1  read request handshake
rd_req_setid_i  in  SET_DEPTH  read set index
rd_rsp_valid_o  out  1  read response valid, no backpressure
rd_rsp_data_o  out  NUM_WAY*GEN_WIDTH  read data, all ways
wr0_valid_i / wr0_ready_o  in/out  1/1  refill write handshake
wr0_setid_i, wr0_waymask_i, wr0_data_i  in  SET_DEPTH, NUM_WAY, NUM_WAY*GEN_WIDTH  refill write payload
wr1_valid_i / wr1_ready_o, wr1_setid_i, wr1_waymask_i, wr1_data_i  same widths  update write channel
flush_valid_i / flush_ready_o  in/out  1/1  flush request handshake
flush_done_o  out  1  1-cycle pulse on the last flush write
init_done_o  out  1  high once the reset sweep completes
sram_r_valid_o, sram_r_setid_o  out  1, SET_DEPTH  to SRAM read port
sram_r_data_i  in  NUM_WAY*GEN_WIDTH  SRAM read data, valid 1 cycle after read
sram_w_valid_o, sram_w_setid_o, sram_w_waymask_o, sram_w_data_o  out  1, SET_DEPTH, NUM_WAY, NUM_WAY*GEN_WIDTH  to SRAM write port

Behaviour:
- Clocking and reset: single clock clk; rst_n asynchronous assert, active-low.
- Reset values: state=SWEEP (init), sweep_cnt=0, rr_ptr=0 (refill favoured), rd_rsp_valid_o=0, init_done_o=0, flush_done_o=0.
- All ready outputs are 0 in reset and in SWEEP.
- FSM states:
  - SWEEP: sram_w_valid_o=1, setid=sweep_cnt, waymask all ones, data all zero. sweep_cnt increments each cycle.
  - SWEEP exit: when sweep_cnt==NUM_SET-1, go to RUN and clear sweep_cnt. Set init_done_o=1 if the sweep was the init sweep; it stays high until reset. Otherwise pulse flush_done_o in that same cycle.
  - RUN: all channels are serviced as below.
  - Reset asserted mid-sweep restarts the init sweep at set 0.
- RUN, reads:
  - rd_req_ready_o=1 unconditionally.
  - A read fires when valid&&ready: sram_r_valid_o=1, sram_r_setid_o=rd_req_setid_i, combinational.
  - rd_rsp_valid_o is asserted exactly 1 cycle after the fire. rd_rsp_data_o passes sram_r_data_i through.
- RUN, writes:
  - At most one write is granted per cycle.
  - If only one writer is valid, it is granted.
  - If both are valid, the writer selected by rr_ptr is granted.
  - After any grant, rr_ptr <= index of the non-granted writer.
  - wrN_ready_o is high only for the granted writer.
  - The granted payload drives the sram_w_* outputs combinationally, with sram_w_valid_o=1.
  - A write with an all-zero waymask is still granted and passed through as-is.
- RUN, flush:
  - flush_ready_o=1 in RUN.
  - On the flush fire cycle, both wr readies are forced to 0; flush outranks writes. The read may still fire in that cycle.
  - In the next cycle the FSM enters SWEEP (flush).
- A read fired in the last RUN cycle still returns its response in the first SWEEP cycle.
- Read and write to the same set in the same cycle are both issued. The SRAM bypass returns the new write data. The controller does not hazard-check.
- When an SRAM port is not issuing, its setid, waymask and data outputs drive zero.
- Sweep counter width is SET_DEPTH. The terminal compare is against NUM_SET-1, so there is no wrap beyond NUM_SET-1.

Decomposition:
- Shared package holds:
  - FSM state encoding (SWEEP, RUN).
  - Sweep-type flag encoding (INIT, FLUSH).
  - Writer index constants (WR_REFILL=0, WR_UPDATE=1).
- Sub-module rr_arb2: 2-input round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Outputs: one-hot gnt, internal ptr.
  - Reused for other two-source SRAM ports in the cache.

Test Plan:
1. Reset, defaults (NUM_SET=32, NUM_WAY=2) -> 32 consecutive sram writes, setid 0..31, waymask 2'b11, data 0. init_done_o rises after setid 31. rd_req_ready_o is first high on the cycle after setid 31.
2. After init, write refill set 5 mask 2'b01 data {32'h0, 32'hA5A5A5A5}, then read set 5 -> rd_rsp_valid_o exactly 1 cycle after the read fire, data low way = 32'hA5A5A5A5.
3. wr0 and wr1 both held valid for 4 cycles -> grants wr0, wr1, wr0, wr1. Exactly one sram_w_valid_o per cycle.
4. Read and wr1 to set 9 in the same cycle, data 64'h1234 -> both SRAM ports issued; next-cycle response = 64'h1234.
5. flush_valid_i with wr0 valid in the same cycle -> wr0_ready_o=0, flush accepted, then 32 zero writes. flush_done_o pulses on setid 31. wr0 is granted on the first RUN cycle after.
6. Assert rst_n low during flush sweep at set 12 -> outputs at reset values, init_done_o=0, sweep restarts from set 0.

Source files
------------

// File: rtl/sram_access_ctrl_pkg.sv
// Purpose: shared encodings for the L1 SRAM access controller and its arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_access_ctrl_pkg;

  // Controller top-level state: zeroing sweep or normal service.
  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Why the current sweep is running; selects init_done vs flush_done at exit.
  typedef enum logic {
    SWEEP_INIT  = 1'b0,
    SWEEP_FLUSH = 1'b1
  } sweep_e;

  // Writer indices into the arbiter request/grant vectors.
  localparam int WR_REFILL = 0;
  localparam int WR_UPDATE = 1;

endpackage

// File: rtl/rr_arb2.sv
// Purpose: two-requester round-robin arbiter with one-hot grant.
// Latency: grant is combinational from req; pointer updates on the next edge.
// Backpressure: the loser of a tie simply sees no grant and retries.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req[1:0]     request per source
//   advance      grant is being consumed this cycle; lets the pointer move
//   gnt[1:0]     one-hot grant (all zero when nothing requests)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // Index of the source that wins a tie; source 0 is favoured out of reset.
  logic ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

  // After any grant the other source becomes favoured, even if the grant
  // was uncontested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// Purpose: front-end for one dual-port set-associative L1 SRAM: init/flush zeroing sweeps, one reader, two arbitrated writers.
// Latency: SRAM requests issue combinationally on fire; read response returns 1 cycle after the read fire.
// Backpressure: all readies low while sweeping; writers arbitrated round-robin; read response has no backpressure.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   rd_req_*                        read request (valid/ready, set index)
//   rd_rsp_valid_o, rd_rsp_data_o   read response, all ways
//   wr0_* (refill), wr1_* (update)  write channels: set, per-way mask, data
//   flush_valid_i/flush_ready_o     flush request; flush_done_o pulses on the last flush write
//   init_done_o                     high once the reset sweep has completed
//   sram_r_*, sram_w_*              SRAM read and write ports
module sram_access_ctrl
  import sram_access_ctrl_pkg::*;
#(
  parameter int GEN_WIDTH = 32,
  parameter int NUM_SET   = 32,
  parameter int NUM_WAY   = 2,
  parameter int SET_DEPTH = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rd_req_valid_i,
  output logic                           rd_req_ready_o,
  input  logic [SET_DEPTH-1:0]           rd_req_setid_i,
  output logic                           rd_rsp_valid_o,
  output logic [NUM_WAY*GEN_WIDTH-1:0]   rd_rsp_data_o,
  input  logic                           wr0_valid_i,
  output logic                           wr0_ready_o,
  input  logic [SET_DEPTH-1:0]           wr0_setid_i,
  input  logic [NUM_WAY-1:0]             wr0_waymask_i,
  input  logic [NUM_WAY*GEN_WIDTH-1:0]   wr0_data_i,
  input  logic                           wr1_valid_i,
  output logic                           wr1_ready_o,
  input  logic [SET_DEPTH-1:0]           wr1_setid_i,
  input  logic [NUM_WAY-1:0]             wr1_waymask_i,
  input  logic [NUM_WAY*GEN_WIDTH-1:0]   wr1_data_i,
  input  logic                           flush_valid_i,
  output logic                           flush_ready_o,
  output logic                           flush_done_o,
  output logic                           init_done_o,
  output logic                           sram_r_valid_o,
  output logic [SET_DEPTH-1:0]           sram_r_setid_o,
  input  logic [NUM_WAY*GEN_WIDTH-1:0]   sram_r_data_i,
  output logic                           sram_w_valid_o,
  output logic [SET_DEPTH-1:0]           sram_w_setid_o,
  output logic [NUM_WAY-1:0]             sram_w_waymask_o,
  output logic [NUM_WAY*GEN_WIDTH-1:0]   sram_w_data_o
);

  localparam logic [SET_DEPTH-1:0] LAST_SET = SET_DEPTH'(NUM_SET - 1);

  state_e               state_q, state_d;
  sweep_e               sweep_q, sweep_d;
  logic [SET_DEPTH-1:0] cnt_q, cnt_d;
  logic                 init_done_q, init_done_d;
  logic                 rsp_valid_q;

  logic       run;
  logic       rd_fire;
  logic       flush_fire;
  logic [1:0] wr_req;
  logic [1:0] wr_gnt;

  assign run        = (state_q == ST_RUN);
  assign rd_fire    = rd_req_valid_i && run;
  assign flush_fire = flush_valid_i && run;

  assign rd_req_ready_o = run;
  assign flush_ready_o  = run;

  // A flush takes the whole write port for its sweep, so writers are held
  // off in the cycle it is accepted.
  always_comb begin
    wr_req            = 2'b00;
    wr_req[WR_REFILL] = wr0_valid_i && run && !flush_fire;
    wr_req[WR_UPDATE] = wr1_valid_i && run && !flush_fire;
  end

  rr_arb2 u_wr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (wr_req),
    .advance (run),
    .gnt     (wr_gnt)
  );

  assign wr0_ready_o = wr_gnt[WR_REFILL];
  assign wr1_ready_o = wr_gnt[WR_UPDATE];

  // Next-state logic. flush_done_o is combinational so it lines up with the
  // last flush write on the SRAM port.
  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    cnt_d        = cnt_q;
    init_done_d  = init_done_q;
    flush_done_o = 1'b0;
    case (state_q)
      ST_SWEEP: begin
        if (cnt_q == LAST_SET) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          if (sweep_q == SWEEP_INIT) begin
            init_done_d = 1'b1;
          end else begin
            flush_done_o = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (flush_fire) begin
          state_d = ST_SWEEP;
          sweep_d = SWEEP_FLUSH;
        end
      end
      default: begin
        state_d = ST_SWEEP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SWEEP;
      sweep_q     <= SWEEP_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rd_fire;
    end
  end

  assign init_done_o    = init_done_q;
  assign rd_rsp_valid_o = rsp_valid_q;
  assign rd_rsp_data_o  = sram_r_data_i;

  // Read port: idle outputs drive zero.
  assign sram_r_valid_o = rd_fire;
  assign sram_r_setid_o = rd_fire ? rd_req_setid_i : '0;

  // Write port: sweep owns it outside RUN, otherwise the granted writer.
  always_comb begin
    sram_w_valid_o   = 1'b0;
    sram_w_setid_o   = '0;
    sram_w_waymask_o = '0;
    sram_w_data_o    = '0;
    if (!run) begin
      sram_w_valid_o   = 1'b1;
      sram_w_setid_o   = cnt_q;
      sram_w_waymask_o = '1;
    end else if (wr_gnt[WR_REFILL]) begin
      sram_w_valid_o   = 1'b1;
      sram_w_setid_o   = wr0_setid_i;
      sram_w_waymask_o = wr0_waymask_i;
      sram_w_data_o    = wr0_data_i;
    end else if (wr_gnt[WR_UPDATE]) begin
      sram_w_valid_o   = 1'b1;
      sram_w_setid_o   = wr1_setid_i;
      sram_w_waymask_o = wr1_waymask_i;
      sram_w_data_o    = wr1_data_i;
    end
  end

endmodule
